// File: rtl/hdu_client_if.sv
// Bus bundle between hdu_client and its environment: upstream request,
// HDU lock/release ports, flush control, status and statistics.
interface hdu_client_if #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 5
);
  logic [ADDR_W-1:0] in_addr;
  logic              in_valid;
  logic              in_ready;
  logic              flush_req;
  logic              flush_done;
  logic [ADDR_W-1:0] Raddr;
  logic              Raddr_valid;
  logic              stall_signal;
  logic              wb_done;
  logic [ADDR_W-1:0] Waddr;
  logic              Waddr_valid;
  logic [CNT_W-1:0]  inflight_cnt;
  logic              err_underflow;
  logic              err_deadlock;
  logic [31:0]       stat_stall;
  logic [31:0]       stat_issued;

  modport slave (
    input  in_addr, in_valid, flush_req, stall_signal, wb_done,
    output in_ready, flush_done, Raddr, Raddr_valid, Waddr, Waddr_valid,
           inflight_cnt, err_underflow, err_deadlock, stat_stall, stat_issued
  );

  modport master (
    output in_addr, in_valid, flush_req, stall_signal, wb_done,
    input  in_ready, flush_done, Raddr, Raddr_valid, Waddr, Waddr_valid,
           inflight_cnt, err_underflow, err_deadlock, stat_stall, stat_issued
  );
endinterface

// File: rtl/hdu_client.sv
// HDU client: issues lock reads, tracks in-flight addresses in a FIFO, releases on write-back.
// Optional statistics counters are enabled by defining HDU_CLIENT_STATS_EN.
module hdu_client #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH+1)
) (
  input  logic         clk,
  input  logic         rst,
  hdu_client_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_FLUSHED} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_raddr, r_waddr;
  logic              r_raddr_vld, r_waddr_vld;
  logic              r_err_uf, r_err_dl, r_dl_pend;
  logic              w_in_ready, w_push, w_pop, w_empty;

  assign w_empty    = (r_cnt == '0);
  assign w_in_ready = (r_state == S_RUN) & ~bus.stall_signal & (r_cnt < CNT_W'(DEPTH));
  assign w_push     = bus.in_valid & w_in_ready;
  // Pops only see entries present at the start of the cycle.
  assign w_pop      = bus.wb_done & ~w_empty;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN:     if (bus.flush_req) w_state_nxt = S_DRAIN;
      S_DRAIN:   if (w_empty && !r_raddr_vld) w_state_nxt = S_FLUSHED;
      S_FLUSHED: if (!bus.flush_req) w_state_nxt = S_RUN;
      default:   w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_RUN;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.in_addr;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_cnt       <= '0;
      r_raddr     <= '0;
      r_raddr_vld <= 1'b0;
      r_waddr     <= '0;
      r_waddr_vld <= 1'b0;
      r_err_uf    <= 1'b0;
      r_err_dl    <= 1'b0;
      r_dl_pend   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
      // A stalled request stays on the HDU port until the stall lifts.
      if (!bus.stall_signal) begin
        r_raddr_vld <= w_push;
        if (w_push) r_raddr <= bus.in_addr;
      end
      r_waddr_vld <= w_pop;
      if (w_pop) r_waddr <= r_mem[r_rd_ptr];
      if (bus.wb_done && w_empty) r_err_uf <= 1'b1;
      r_dl_pend <= bus.stall_signal & w_empty;
      if (bus.stall_signal && w_empty && r_dl_pend) r_err_dl <= 1'b1;
    end
  end

  assign bus.in_ready      = w_in_ready;
  assign bus.flush_done    = (r_state == S_FLUSHED);
  assign bus.Raddr         = r_raddr;
  assign bus.Raddr_valid   = r_raddr_vld;
  assign bus.Waddr         = r_waddr;
  assign bus.Waddr_valid   = r_waddr_vld;
  assign bus.inflight_cnt  = r_cnt;
  assign bus.err_underflow = r_err_uf;
  assign bus.err_deadlock  = r_err_dl;

`ifdef HDU_CLIENT_STATS_EN
  logic [31:0] r_stat_stall, r_stat_issued;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stat_stall  <= '0;
      r_stat_issued <= '0;
    end else begin
      if (bus.stall_signal && r_stat_stall != '1) r_stat_stall  <= r_stat_stall + 32'd1;
      if (w_push && r_stat_issued != '1)          r_stat_issued <= r_stat_issued + 32'd1;
    end
  end

  assign bus.stat_stall  = r_stat_stall;
  assign bus.stat_issued = r_stat_issued;
`else
  assign bus.stat_stall  = '0;
  assign bus.stat_issued = '0;
`endif
endmodule
